ts_lane_deskew: RTL and testbench
=================================

TS_LANE_DESKEW -- requirements
Module: ts_lane_deskew

Interface
REQ-001 SHALL have parameter DEPTH, default 8, per-lane FIFO depth in entries; a power of 2 and at least 4.
REQ-002 SHALL have parameter MAX_SKEW, default 16, the maximum number of cycles allowed between the first and last active-lane arrival.
REQ-003 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 SHALL have ports lane0_ts_i..lane3_ts_i, input, 128 bits each: received TS ordered set per lane, taken from the peer LTSSM's laneN_ts_o.
REQ-006 SHALL have ports lane0_ts_i_vld..lane3_ts_i_vld, input, 1 bit each: TS-valid strobe per lane.
REQ-007 SHALL have port lane_mask, input, 4 bits: bit N=1 means lane N participates (x1=0001, x2=0011, x4=1111).
REQ-008 SHALL have ports lane0_ts_o..lane3_ts_o, output, 128 bits each: deskewed TS per lane.
REQ-009 SHALL have port ts_o_vld, output, 1 bit: common valid for all deskewed lanes.
REQ-010 SHALL have port aligned, output, 1 bit: high while the state is LOCKED.
REQ-011 SHALL have port deskew_err, output, 1 bit: one-cycle error pulse.
REQ-012 SHALL have port skew_cnt, output, 8 bits: measured arrival skew, in cycles, latched at lock.

Function
REQ-013 SHALL have states IDLE, ALIGN, LOCKED and ERR, using a single FSM.
REQ-014 SHALL sample lane_mask into an active-mask register only while in IDLE; lane_mask changes in other states take effect on the next IDLE.
REQ-015 SHALL, with an active mask of 0000, remain in IDLE and discard all inputs.
REQ-016 SHALL, in any state except ERR, write laneN_ts_i into lane N's FIFO on each cycle laneN_ts_i_vld=1 and N is active; inactive lanes are never written.
REQ-017 SHALL make written data visible to the pop logic the following cycle (no fall-through).
REQ-018 SHALL transition IDLE->ALIGN on the first active-lane write and clear the skew counter to 0.
REQ-019 SHALL increment the skew counter once per cycle in ALIGN, saturating at 255.
REQ-020 SHALL define pop = (state is ALIGN or LOCKED) AND every active FIFO is non-empty; pop reads one entry from each active FIFO.
REQ-021 SHALL, on the first pop in ALIGN, move to LOCKED and latch the skew counter into skew_cnt.
REQ-022 SHALL, in ALIGN, go to ERR when the skew counter equals MAX_SKEW and pop=0.
REQ-023 SHALL register outputs: the cycle after a pop, ts_o_vld=1 and laneN_ts_o carries the popped data; inactive lanes output 0; ts_o_vld=0 otherwise, with laneN_ts_o holding its last value.
REQ-024 SHALL give latency of 2 cycles from input valid to ts_o_vld when all active lanes arrive in the same cycle.
REQ-025 SHALL treat a write to a full FIFO as overflow, with no pop that cycle, and go to ERR; the data is dropped.
REQ-026 SHALL, on a write and pop in the same cycle on a full FIFO, pop first then write, with no overflow.
REQ-027 SHALL, in ERR, assert deskew_err for exactly one cycle, flush all FIFO pointers, force ts_o_vld=0, and return to IDLE the next cycle.
REQ-028 SHALL ignore inputs during the ERR cycle.
REQ-029 SHALL keep LOCKED indefinitely while no overflow occurs; FIFO empty in LOCKED is not an error.
REQ-030 SHALL keep FIFO pointers at log2(DEPTH)+1 bits, with wrap-around; full when the MSBs differ and the rest are equal.

Reset
REQ-031 SHALL, on rst=1 at a clock edge, enter IDLE, empty all FIFOs, clear the active mask, and drive ts_o_vld=0, aligned=0, deskew_err=0, skew_cnt=0 and all laneN_ts_o=0.
REQ-032 SHALL allow rst mid-operation (ALIGN or LOCKED) to discard all buffered data, with no deskew_err pulse.

Verification
REQ-033 SHALL cover: mask=1111, all four lanes vld at cycle t with distinct data -> ts_o_vld=1 at t+2 with matching data, aligned=1, skew_cnt=0.
REQ-034 SHALL cover: mask=1111, lanes arrive at t, t+1, t+3, t+5 -> lock, skew_cnt=5, outputs carry the first TS of each lane together.
REQ-035 SHALL cover: mask=1111, lane3 never valid -> deskew_err pulse 16 cycles after the first arrival, then IDLE with aligned=0.
REQ-036 SHALL cover: mask=0011, lanes 2/3 driven with garbage -> lane2_ts_o=lane3_ts_o=0 and lock on lanes 0/1 only.
REQ-037 SHALL cover: LOCKED with lane1 stalled while lane0 writes 9 consecutive entries (DEPTH=8) -> deskew_err on the 9th write, FIFOs flushed.
REQ-038 SHALL cover: rst asserted in LOCKED with 3 entries buffered -> next cycle IDLE, ts_o_vld=0, no deskew_err, and no stale data output after a re-lock.

Source files
------------

// File: rtl/ts_lane_deskew.sv
// Purpose: aligns TS ordered sets across up to four lanes through per-lane FIFOs and a single lock FSM.
// Latency: 2 cycles from input valid to ts_o_vld when all active lanes arrive in the same cycle.
// Backpressure: none upstream; a write into a full FIFO that is not popping that cycle is an overflow and forces ERR.
module ts_lane_deskew #(
  parameter int DEPTH    = 8,
  parameter int MAX_SKEW = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [127:0] lane0_ts_i,
  input  logic [127:0] lane1_ts_i,
  input  logic [127:0] lane2_ts_i,
  input  logic [127:0] lane3_ts_i,
  input  logic         lane0_ts_i_vld,
  input  logic         lane1_ts_i_vld,
  input  logic         lane2_ts_i_vld,
  input  logic         lane3_ts_i_vld,
  input  logic [3:0]   lane_mask,
  output logic [127:0] lane0_ts_o,
  output logic [127:0] lane1_ts_o,
  output logic [127:0] lane2_ts_o,
  output logic [127:0] lane3_ts_o,
  output logic         ts_o_vld,
  output logic         aligned,
  output logic         deskew_err,
  output logic [7:0]   skew_cnt
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [1:0] {IDLE, ALIGN, LOCKED, ERR} state_t;

  state_t       r_state;
  logic [3:0]   r_mask;
  logic [7:0]   r_cnt;
  logic [7:0]   r_skew;
  logic         r_aligned;
  logic         r_err;
  logic         r_vld;
  logic [127:0] r_ts_o [4];
  logic [127:0] r_mem  [4][DEPTH];
  logic [AW:0]  r_wp   [4];
  logic [AW:0]  r_rp   [4];

  logic [127:0] w_ts_in [4];
  logic [3:0]   w_vld;
  logic [3:0]   w_act;
  logic [3:0]   w_empty;
  logic [3:0]   w_full;
  logic [3:0]   w_req;
  logic [3:0]   w_ovf_lane;
  logic [3:0]   w_wr;
  logic         w_pop;
  logic         w_ovf;

  assign w_ts_in[0] = lane0_ts_i;
  assign w_ts_in[1] = lane1_ts_i;
  assign w_ts_in[2] = lane2_ts_i;
  assign w_ts_in[3] = lane3_ts_i;
  assign w_vld      = {lane3_ts_i_vld, lane2_ts_i_vld, lane1_ts_i_vld, lane0_ts_i_vld};

  // In IDLE the live mask decides which lanes may start an alignment; afterwards the sampled copy rules.
  assign w_act = (r_state == IDLE) ? lane_mask : r_mask;

  // Per-lane FIFO status from the extra pointer MSB: equal means empty, MSB-only difference means full.
  always_comb begin
    w_empty = '0;
    w_full  = '0;
    for (int n = 0; n < 4; n++) begin
      w_empty[n] = (r_wp[n] == r_rp[n]);
      w_full[n]  = (r_wp[n][AW] != r_rp[n][AW]) && (r_wp[n][AW-1:0] == r_rp[n][AW-1:0]);
    end
  end

  assign w_pop      = ((r_state == ALIGN) || (r_state == LOCKED)) && (r_mask != 4'b0000) &&
                      ((w_empty & r_mask) == 4'b0000);
  assign w_req      = w_vld & w_act & {4{r_state != ERR}};
  // A pop on the same cycle frees a slot first, so a full FIFO only overflows when nothing is popped.
  assign w_ovf_lane = w_req & w_full & {4{~w_pop}};
  assign w_ovf      = |w_ovf_lane;
  assign w_wr       = w_req & ~w_ovf_lane;

  // Lock FSM with registered status outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= IDLE;
      r_mask    <= 4'b0000;
      r_cnt     <= 8'd0;
      r_skew    <= 8'd0;
      r_aligned <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_err <= 1'b0;
      case (r_state)
        IDLE: begin
          r_mask <= lane_mask;
          if (|w_wr) begin
            r_state <= ALIGN;
            r_cnt   <= 8'd0;
          end
        end
        ALIGN: begin
          if (r_cnt != 8'hFF) r_cnt <= r_cnt + 8'd1;
          if (w_ovf) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end else if (w_pop) begin
            r_state   <= LOCKED;
            r_aligned <= 1'b1;
            r_skew    <= r_cnt;
          end else if (r_cnt == 8'(MAX_SKEW)) begin
            r_state <= ERR;
            r_err   <= 1'b1;
          end
        end
        LOCKED: begin
          if (w_ovf) begin
            r_state   <= ERR;
            r_aligned <= 1'b0;
            r_err     <= 1'b1;
          end
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // FIFO pointers and the registered deskewed output stage; ERR flushes every lane.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_vld <= 1'b0;
      for (int n = 0; n < 4; n++) begin
        r_wp[n]   <= '0;
        r_rp[n]   <= '0;
        r_ts_o[n] <= '0;
      end
    end else begin
      r_vld <= w_pop;
      for (int n = 0; n < 4; n++) begin
        if (r_state == ERR) begin
          r_wp[n] <= '0;
          r_rp[n] <= '0;
        end else begin
          if (w_wr[n]) r_wp[n] <= r_wp[n] + (AW+1)'(1);
          if (w_pop && r_mask[n]) r_rp[n] <= r_rp[n] + (AW+1)'(1);
        end
        if (w_pop) r_ts_o[n] <= r_mask[n] ? r_mem[n][r_rp[n][AW-1:0]] : '0;
      end
    end
  end

  // FIFO storage; no reset needed since the pointers define what is valid.
  always_ff @(posedge clk) begin
    for (int n = 0; n < 4; n++) begin
      if (w_wr[n]) r_mem[n][r_wp[n][AW-1:0]] <= w_ts_in[n];
    end
  end

  assign lane0_ts_o = r_ts_o[0];
  assign lane1_ts_o = r_ts_o[1];
  assign lane2_ts_o = r_ts_o[2];
  assign lane3_ts_o = r_ts_o[3];
  assign ts_o_vld   = r_vld;
  assign aligned    = r_aligned;
  assign deskew_err = r_err;
  assign skew_cnt   = r_skew;

endmodule

// File: tb/tb_ts_lane_deskew.sv
// Directed bench for ts_lane_deskew: reset, aligned lock, skewed lock, skew timeout,
// partial-width mask, FIFO overflow and reset while locked.
module tb_ts_lane_deskew;

  logic         clk = 1'b0;
  logic         rst;
  logic [127:0] ts_i [4];
  logic [3:0]   vld;
  logic [3:0]   lane_mask;
  logic [127:0] lane0_ts_o, lane1_ts_o, lane2_ts_o, lane3_ts_o;
  logic         ts_o_vld, aligned, deskew_err;
  logic [7:0]   skew_cnt;

  int n_vec = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ts_lane_deskew #(.DEPTH(8), .MAX_SKEW(16)) dut (
    .clk            (clk),
    .rst            (rst),
    .lane0_ts_i     (ts_i[0]),
    .lane1_ts_i     (ts_i[1]),
    .lane2_ts_i     (ts_i[2]),
    .lane3_ts_i     (ts_i[3]),
    .lane0_ts_i_vld (vld[0]),
    .lane1_ts_i_vld (vld[1]),
    .lane2_ts_i_vld (vld[2]),
    .lane3_ts_i_vld (vld[3]),
    .lane_mask      (lane_mask),
    .lane0_ts_o     (lane0_ts_o),
    .lane1_ts_o     (lane1_ts_o),
    .lane2_ts_o     (lane2_ts_o),
    .lane3_ts_o     (lane3_ts_o),
    .ts_o_vld       (ts_o_vld),
    .aligned        (aligned),
    .deskew_err     (deskew_err),
    .skew_cnt       (skew_cnt)
  );

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Outputs are sampled 1 time unit after the rising edge; inputs change at the same point.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] mk(input int tag, input int lane);
    return {32'(tag), 32'(lane), 32'hDEADBEEF, 32'(tag * 16 + lane)};
  endfunction

  task automatic set_all(input int tag, input logic [3:0] v);
    for (int n = 0; n < 4; n++) ts_i[n] = mk(tag, n);
    vld = v;
  endtask

  task automatic pulse_rst();
    rst = 1'b1;
    vld = 4'b0000;
    tick();
    rst = 1'b0;
  endtask

  task automatic chk_lanes(input string tag, input int dtag, input logic [3:0] m);
    chk({tag, "_l0"}, lane0_ts_o, m[0] ? mk(dtag, 0) : 128'd0);
    chk({tag, "_l1"}, lane1_ts_o, m[1] ? mk(dtag, 1) : 128'd0);
    chk({tag, "_l2"}, lane2_ts_o, m[2] ? mk(dtag, 2) : 128'd0);
    chk({tag, "_l3"}, lane3_ts_o, m[3] ? mk(dtag, 3) : 128'd0);
  endtask

  initial begin
    int errs;
    int at;

    rst       = 1'b1;
    lane_mask = 4'b0000;
    vld       = 4'b0000;
    for (int n = 0; n < 4; n++) ts_i[n] = '0;
    tick();
    tick();

    // Reset state
    chk("rst_vld", ts_o_vld, 0);
    chk("rst_aligned", aligned, 0);
    chk("rst_err", deskew_err, 0);
    chk("rst_skew", skew_cnt, 0);
    chk_lanes("rst", 0, 4'b0000);
    rst = 1'b0;

    // Empty mask: inputs are discarded and the FSM stays idle
    set_all(9, 4'b1111);
    tick(); tick(); tick();
    vld = 4'b0000;
    chk("m0_aligned", aligned, 0);
    chk("m0_vld", ts_o_vld, 0);
    tick();
    chk("m0_vld2", ts_o_vld, 0);
    lane_mask = 4'b1111;
    tick();

    // x4, all lanes in the same cycle: valid two cycles later
    set_all(1, 4'b1111);
    tick();
    vld = 4'b0000;
    chk("same_vld_t1", ts_o_vld, 0);
    tick();
    chk("same_vld_t2", ts_o_vld, 1);
    chk_lanes("same", 1, 4'b1111);
    chk("same_aligned", aligned, 1);
    chk("same_skew", skew_cnt, 0);
    tick();
    chk("same_vld_t3", ts_o_vld, 0);
    chk("same_hold", lane0_ts_o, mk(1, 0));

    // x4 with arrivals at t, t+1, t+3, t+5
    pulse_rst();
    for (int n = 0; n < 4; n++) ts_i[n] = mk(3, n);
    for (int c = 0; c <= 5; c++) begin
      vld[0] = (c == 0);
      vld[1] = (c == 1);
      vld[2] = (c == 3);
      vld[3] = (c == 5);
      tick();
    end
    vld = 4'b0000;
    chk("skew_vld_pre", ts_o_vld, 0);
    chk("skew_aligned_pre", aligned, 0);
    tick();
    chk("skew_vld", ts_o_vld, 1);
    chk_lanes("skew", 3, 4'b1111);
    chk("skew_cnt", skew_cnt, 5);
    chk("skew_aligned", aligned, 1);

    // x4 with lane3 silent: skew timeout, one error pulse, back to idle
    pulse_rst();
    set_all(4, 4'b0111);
    errs = 0;
    at   = -1;
    for (int i = 1; i <= 25; i++) begin
      tick();
      vld = 4'b0000;
      if (deskew_err) begin
        errs++;
        if (at < 0) at = i;
      end
    end
    chk("tmo_pulses", errs, 1);
    chk("tmo_window", (at >= 16 && at <= 18), 1);
    chk("tmo_aligned", aligned, 0);
    chk("tmo_vld", ts_o_vld, 0);
    // Flushed FIFOs: a fresh lock must carry only the new sets
    set_all(5, 4'b1111);
    tick();
    vld = 4'b0000;
    tick();
    chk("tmo_relock_vld", ts_o_vld, 1);
    chk_lanes("tmo_relock", 5, 4'b1111);

    // x2 mask with garbage on lanes 2/3
    pulse_rst();
    lane_mask = 4'b0011;
    set_all(6, 4'b1111);
    tick();
    vld = 4'b0000;
    tick();
    chk("x2_vld", ts_o_vld, 1);
    chk_lanes("x2", 6, 4'b0011);
    chk("x2_aligned", aligned, 1);

    // Locked x2, lane1 stalled, lane0 writes 9 entries: 9th overflows
    for (int i = 1; i <= 9; i++) begin
      ts_i[0] = mk(70 + i, 0);
      vld     = 4'b0001;
      tick();
      chk($sformatf("ovf_err_%0d", i), deskew_err, (i == 9));
      chk($sformatf("ovf_vld_%0d", i), ts_o_vld, 0);
    end
    vld = 4'b0000;
    tick();
    chk("ovf_err_after", deskew_err, 0);
    chk("ovf_aligned", aligned, 0);
    set_all(8, 4'b0011);
    tick();
    vld = 4'b0000;
    tick();
    chk("ovf_relock_vld", ts_o_vld, 1);
    chk_lanes("ovf_relock", 8, 4'b0011);

    // Reset while locked with 3 entries buffered on lane0
    pulse_rst();
    lane_mask = 4'b1111;
    set_all(10, 4'b1111);
    tick();
    vld = 4'b0000;
    tick();
    chk("rl_lock", aligned, 1);
    for (int i = 0; i < 3; i++) begin
      ts_i[0] = mk(11 + i, 0);
      vld     = 4'b0001;
      tick();
    end
    vld = 4'b0000;
    pulse_rst();
    chk("rl_vld", ts_o_vld, 0);
    chk("rl_err", deskew_err, 0);
    chk("rl_aligned", aligned, 0);
    chk("rl_l0", lane0_ts_o, 128'd0);
    tick();
    chk("rl_err2", deskew_err, 0);
    set_all(12, 4'b1111);
    tick();
    vld = 4'b0000;
    tick();
    chk("rl_relock_vld", ts_o_vld, 1);
    chk_lanes("rl_relock", 12, 4'b1111);
    chk("rl_relock_skew", skew_cnt, 0);
    tick();
    chk("rl_no_stale", ts_o_vld, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
